layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_pkg.sv | 50 +++++
 rtl/layer_desc_fifo.sv | 86 ++++++++
 rtl/layer_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared types and constants for the layer sequencer: FSM states,
// the five-field layer descriptor, staging-register selects and the
// bit positions of the fields decoded for base-address generation.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_RUN  = 3'd3,
        ST_WAIT = 3'd4,
        ST_FIN  = 3'd5
    } seq_state_t;

    // One queued layer: everything the pass controller needs for a layer.
    typedef struct packed {
        logic [31:0] op_config;
        logic [31:0] mapping_param;
        logic [31:0] shape_param1;
        logic [31:0] shape_param2;
        logic        bias_ipsum_sel;
    } layer_desc_t;

    // cfg_wsel encodings for the staging registers
    localparam logic [2:0] WSEL_MAPPING   = 3'd0;
    localparam logic [2:0] WSEL_SHAPE1    = 3'd1;
    localparam logic [2:0] WSEL_SHAPE2    = 3'd2;
    localparam logic [2:0] WSEL_BIAS_SEL  = 3'd3;
    localparam logic [2:0] WSEL_OP_CONFIG = 3'd4;

    // mapping_param fields: t, r, q, p are 3 bits wide, e is 5 bits wide
    localparam int MP_FIELD_W = 3;
    localparam int MP_T_LSB   = 0;
    localparam int MP_R_LSB   = 3;
    localparam int MP_Q_LSB   = 6;
    localparam int MP_P_LSB   = 9;
    localparam int MP_E_LSB   = 12;
    localparam int MP_E_W     = 5;

    // shape_param1 fields: filter width S, filter height R, stride U (2 bits each)
    localparam int SP1_FIELD_W = 2;
    localparam int SP1_S_LSB   = 20;
    localparam int SP1_R_LSB   = 22;
    localparam int SP1_U_LSB   = 24;

    // shape_param2 field: ifmap width W
    localparam int SP2_W_LSB = 8;
    localparam int SP2_W_W   = 8;

endpackage

// File: rtl/layer_desc_fifo.sv
// Synchronous descriptor queue. Storage is a plain array written on push;
// the head is read into a register on pop, so the popped descriptor is
// available the cycle after the pop and stays there as the active layer.
module layer_desc_fifo
    import layer_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  layer_desc_t            wr_data,
    input  logic                   pop,
    output layer_desc_t            rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   push_dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    layer_desc_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    layer_desc_t      rd_data_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A push into a full queue still lands when the head leaves in the same
    // cycle; flush wins over everything.
    assign pop_ok       = pop && !flush && !empty;
    assign push_ok      = push && !flush && (!full || pop_ok);
    assign push_dropped = push && !flush && full && !pop_ok;

    // Storage write; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Registered head read, captured on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: stages descriptors through a small config port, queues
// them, and walks the queue one layer at a time -- load, compute GLB base
// addresses, kick the pass controller, wait for it to finish.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wen,
    input  logic [2:0]             cfg_wsel,
    input  logic [31:0]            cfg_wdata,
    input  logic                   cfg_push,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ctrl_done,
    output logic [31:0]            op_config,
    output logic [31:0]            mapping_param,
    output logic [31:0]            shape_param1,
    output logic [31:0]            shape_param2,
    output logic                   bias_ipsum_sel,
    output logic [ADDR_W-1:0]      ifmap_baseaddr,
    output logic [ADDR_W-1:0]      filter_baseaddr,
    output logic [ADDR_W-1:0]      bias_baseaddr,
    output logic [ADDR_W-1:0]      opsum_baseaddr,
    output logic                   ctrl_start,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_full,
    output logic [$clog2(DEPTH):0] cfg_count,
    output logic [7:0]             layer_idx,
    output logic                   overflow
);

    seq_state_t        state_reg;
    seq_state_t        state_next;
    layer_desc_t       stage_reg;
    layer_desc_t       active_desc;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              push_dropped;
    logic              start_accept;
    logic [7:0]        layer_idx_reg;
    logic              overflow_reg;
    logic [ADDR_W-1:0] filter_addr_reg;
    logic [ADDR_W-1:0] bias_addr_reg;
    logic [ADDR_W-1:0] opsum_addr_reg;

    // Decoded fields widened to 64 bits so the products cannot overflow
    // before the final truncation to ADDR_W.
    logic [63:0] m_t, m_r, m_q, m_p, m_e, e_eff;
    logic [63:0] k_r, k_s, k_u, i_w;
    logic [63:0] filter_full, bias_full, opsum_full;

    // Staging registers; a push in the same cycle as a write commits the
    // value held before that write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else if (cfg_wen) begin
            case (cfg_wsel)
                WSEL_MAPPING:   stage_reg.mapping_param  <= cfg_wdata;
                WSEL_SHAPE1:    stage_reg.shape_param1   <= cfg_wdata;
                WSEL_SHAPE2:    stage_reg.shape_param2   <= cfg_wdata;
                WSEL_BIAS_SEL:  stage_reg.bias_ipsum_sel <= cfg_wdata[0];
                WSEL_OP_CONFIG: stage_reg.op_config      <= cfg_wdata;
                default:        stage_reg                <= stage_reg;
            endcase
        end
    end

    layer_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_desc_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (abort),
        .push         (cfg_push),
        .wr_data      (stage_reg),
        .pop          (fifo_pop),
        .rd_data      (active_desc),
        .full         (cfg_full),
        .empty        (fifo_empty),
        .count        (cfg_count),
        .push_dropped (push_dropped)
    );

    // Base-address arithmetic from the active descriptor; e of zero counts as one.
    always_comb begin
        m_t   = 64'(active_desc.mapping_param[MP_T_LSB +: MP_FIELD_W]);
        m_r   = 64'(active_desc.mapping_param[MP_R_LSB +: MP_FIELD_W]);
        m_q   = 64'(active_desc.mapping_param[MP_Q_LSB +: MP_FIELD_W]);
        m_p   = 64'(active_desc.mapping_param[MP_P_LSB +: MP_FIELD_W]);
        m_e   = 64'(active_desc.mapping_param[MP_E_LSB +: MP_E_W]);
        k_s   = 64'(active_desc.shape_param1[SP1_S_LSB +: SP1_FIELD_W]);
        k_r   = 64'(active_desc.shape_param1[SP1_R_LSB +: SP1_FIELD_W]);
        k_u   = 64'(active_desc.shape_param1[SP1_U_LSB +: SP1_FIELD_W]);
        i_w   = 64'(active_desc.shape_param2[SP2_W_LSB +: SP2_W_W]);
        e_eff = (m_e == 64'd0) ? 64'd1 : m_e;
        filter_full = m_q * m_r * (k_u * (e_eff - 64'd1) + k_r) * i_w;
        bias_full   = filter_full + m_p * m_t * m_q * m_r * k_r * k_s;
        opsum_full  = bias_full + m_p * m_t * 64'd4;
    end

    // Base addresses are captured once per layer, in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_addr_reg <= '0;
            bias_addr_reg   <= '0;
            opsum_addr_reg  <= '0;
        end else if (state_reg == ST_CALC) begin
            filter_addr_reg <= ADDR_W'(filter_full);
            bias_addr_reg   <= ADDR_W'(bias_full);
            opsum_addr_reg  <= ADDR_W'(opsum_full);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and Moore outputs; abort overrides every state.
    always_comb begin
        state_next   = state_reg;
        fifo_pop     = 1'b0;
        ctrl_start   = 1'b0;
        done         = 1'b0;
        busy         = (state_reg != ST_IDLE);
        start_accept = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !fifo_empty) begin
                    start_accept = 1'b1;
                    state_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_pop   = 1'b1;
                state_next = ST_CALC;
            end
            ST_CALC: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                ctrl_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctrl_done) begin
                    state_next = fifo_empty ? ST_FIN : ST_LOAD;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_next   = ST_IDLE;
            fifo_pop     = 1'b0;
            ctrl_start   = 1'b0;
            done         = 1'b0;
            start_accept = 1'b0;
        end
    end

    // Layer counter: cleared by an accepted start or abort, bumped per completed layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx_reg <= '0;
        end else if (abort || start_accept) begin
            layer_idx_reg <= '0;
        end else if (state_reg == ST_WAIT && ctrl_done) begin
            layer_idx_reg <= layer_idx_reg + 8'd1;
        end
    end

    // Sticky overflow flag for pushes dropped at a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (abort) begin
            overflow_reg <= 1'b0;
        end else if (push_dropped) begin
            overflow_reg <= 1'b1;
        end
    end

    assign op_config       = active_desc.op_config;
    assign mapping_param   = active_desc.mapping_param;
    assign shape_param1    = active_desc.shape_param1;
    assign shape_param2    = active_desc.shape_param2;
    assign bias_ipsum_sel  = active_desc.bias_ipsum_sel;
    assign ifmap_baseaddr  = '0;
    assign filter_baseaddr = filter_addr_reg;
    assign bias_baseaddr   = bias_addr_reg;
    assign opsum_baseaddr  = opsum_addr_reg;
    assign layer_idx       = layer_idx_reg;
    assign overflow        = overflow_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed testbench for layer_sequencer (DEPTH=4, ADDR_W=32).
module tb_layer_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_wen;
    logic [2:0]  cfg_wsel;
    logic [31:0] cfg_wdata;
    logic        cfg_push;
    logic        start;
    logic        abort;
    logic        ctrl_done;
    logic [31:0] op_config, mapping_param, shape_param1, shape_param2;
    logic        bias_ipsum_sel;
    logic [31:0] ifmap_baseaddr, filter_baseaddr, bias_baseaddr, opsum_baseaddr;
    logic        ctrl_start, busy, done, cfg_full, overflow;
    logic [2:0]  cfg_count;
    logic [7:0]  layer_idx;

    int tests_run;
    int tests_failed;

    layer_sequencer #(
        .DEPTH  (4),
        .ADDR_W (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wen         (cfg_wen),
        .cfg_wsel        (cfg_wsel),
        .cfg_wdata       (cfg_wdata),
        .cfg_push        (cfg_push),
        .start           (start),
        .abort           (abort),
        .ctrl_done       (ctrl_done),
        .op_config       (op_config),
        .mapping_param   (mapping_param),
        .shape_param1    (shape_param1),
        .shape_param2    (shape_param2),
        .bias_ipsum_sel  (bias_ipsum_sel),
        .ifmap_baseaddr  (ifmap_baseaddr),
        .filter_baseaddr (filter_baseaddr),
        .bias_baseaddr   (bias_baseaddr),
        .opsum_baseaddr  (opsum_baseaddr),
        .ctrl_start      (ctrl_start),
        .busy            (busy),
        .done            (done),
        .cfg_full        (cfg_full),
        .cfg_count       (cfg_count),
        .layer_idx       (layer_idx),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_mp(input int t, input int r, input int q, input int p, input int e);
        logic [31:0] v;
        v = '0;
        v[2:0]   = t[2:0];
        v[5:3]   = r[2:0];
        v[8:6]   = q[2:0];
        v[11:9]  = p[2:0];
        v[16:12] = e[4:0];
        return v;
    endfunction

    function automatic logic [31:0] mk_sp1(input int kr, input int ks, input int ku);
        logic [31:0] v;
        v = '0;
        v[23:22] = kr[1:0];
        v[21:20] = ks[1:0];
        v[25:24] = ku[1:0];
        return v;
    endfunction

    function automatic logic [31:0] mk_sp2(input int w);
        logic [31:0] v;
        v = '0;
        v[15:8] = w[7:0];
        return v;
    endfunction

    task automatic cfg_write(input logic [2:0] sel, input logic [31:0] d);
        cfg_wen   = 1'b1;
        cfg_wsel  = sel;
        cfg_wdata = d;
        tick();
        cfg_wen   = 1'b0;
    endtask

    task automatic push_desc(input logic [31:0] mp, input logic [31:0] sp1, input logic [31:0] sp2,
                             input logic [31:0] oc, input logic bs);
        cfg_write(3'd0, mp);
        cfg_write(3'd1, sp1);
        cfg_write(3'd2, sp2);
        cfg_write(3'd3, {31'b0, bs});
        cfg_write(3'd4, oc);
        cfg_push = 1'b1;
        tick();
        cfg_push = 1'b0;
        $display("[TB] push mp=%h sp1=%h sp2=%h oc=%h count=%0d full=%0b ovf=%0b",
                 mp, sp1, sp2, oc, cfg_count, cfg_full, overflow);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests_run++;
        if (done !== 1'b0 || ctrl_start !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pulses: done=%0b ctrl_start=%0b want 0,0", done, ctrl_start);
        end
        tests_run++;
        if (cfg_count !== 3'd0 || cfg_full !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++; $display("FAIL reset_queue: count=%0d full=%0b ovf=%0b want 0,0,0", cfg_count, cfg_full, overflow);
        end
        tests_run++;
        if (filter_baseaddr !== 32'd0 || op_config !== 32'd0 || layer_idx !== 8'd0) begin
            tests_failed++; $display("FAIL reset_regs: filter=%0d op=%h idx=%0d want 0", filter_baseaddr, op_config, layer_idx);
        end
        rst_n = 1'b1;
        tick();
        $display("[TB] reset released");
    endtask

    task automatic test_single_layer();
        int lat;
        push_desc(mk_mp(2, 1, 1, 2, 4), mk_sp1(3, 3, 1), mk_sp2(8), 32'hA5A5_0001, 1'b1);
        tests_run++;
        if (cfg_count !== 3'd1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", cfg_count); end
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!ctrl_start && lat < 20) begin tick(); lat++; end
        $display("[TB] single layer ctrl_start latency=%0d", lat);
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL single_latency: got %0d want 3", lat); end
        tests_run++;
        if (filter_baseaddr !== 32'd48 || bias_baseaddr !== 32'd84 || opsum_baseaddr !== 32'd100 || ifmap_baseaddr !== 32'd0) begin
            tests_failed++;
            $display("FAIL single_addrs: got ifmap=%0d filter=%0d bias=%0d opsum=%0d want 0,48,84,100",
                     ifmap_baseaddr, filter_baseaddr, bias_baseaddr, opsum_baseaddr);
        end
        tests_run++;
        if (op_config !== 32'hA5A5_0001 || bias_ipsum_sel !== 1'b1 || shape_param2 !== 32'h0000_0800) begin
            tests_failed++;
            $display("FAIL single_fields: got op=%h bsel=%0b sp2=%h want a5a50001,1,00000800", op_config, bias_ipsum_sel, shape_param2);
        end
        tick();
        tests_run++;
        if (ctrl_start !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL single_pulse_width: ctrl_start=%0b busy=%0b want 0,1", ctrl_start, busy);
        end
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        tests_run++;
        if (done !== 1'b1 || layer_idx !== 8'd1) begin
            tests_failed++; $display("FAIL single_done: done=%0b idx=%0d want 1,1", done, layer_idx);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || layer_idx !== 8'd1) begin
            tests_failed++; $display("FAIL single_idle: done=%0b busy=%0b idx=%0d want 0,0,1", done, busy, layer_idx);
        end
    endtask

    task automatic test_multi_layer();
        int nstart, ndone, dly;
        for (int k = 1; k <= 3; k++) begin
            push_desc(mk_mp(1, 1, 1, 1, 2), mk_sp1(1, 1, 1), mk_sp2(4), 32'(k), 1'b0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        nstart = 0; ndone = 0; dly = 0;
        for (int i = 0; i < 120; i++) begin
            ctrl_done = 1'b0;
            if (done) ndone++;
            if (ctrl_start) begin
                nstart++;
                dly = 10;
                $display("[TB] multi ctrl_start #%0d op=%0d", nstart, op_config);
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) ctrl_done = 1'b1;
            end
            tick();
        end
        ctrl_done = 1'b0;
        tests_run++;
        if (nstart !== 3) begin tests_failed++; $display("FAIL multi_starts: got %0d want 3", nstart); end
        tests_run++;
        if (ndone !== 1) begin tests_failed++; $display("FAIL multi_done: got %0d want 1", ndone); end
        tests_run++;
        if (layer_idx !== 8'd3 || busy !== 1'b0 || cfg_count !== 3'd0) begin
            tests_failed++; $display("FAIL multi_end: idx=%0d busy=%0b count=%0d want 3,0,0", layer_idx, busy, cfg_count);
        end
    endtask

    task automatic test_overflow();
        int nstart, dly;
        for (int k = 1; k <= 5; k++) begin
            push_desc(mk_mp(1, 1, 1, 1, 1), mk_sp1(1, 1, 1), mk_sp2(1), 32'(k), 1'b0);
        end
        tests_run++;
        if (cfg_full !== 1'b1 || cfg_count !== 3'd4 || overflow !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_flags: full=%0b count=%0d ovf=%0b want 1,4,1", cfg_full, cfg_count, overflow);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        nstart = 0; dly = 0;
        for (int i = 0; i < 150; i++) begin
            ctrl_done = 1'b0;
            if (ctrl_start) begin
                nstart++;
                dly = 10;
                tests_run++;
                if (op_config !== 32'(nstart)) begin
                    tests_failed++; $display("FAIL ovf_order: layer %0d op=%0d want %0d", nstart, op_config, nstart);
                end
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) ctrl_done = 1'b1;
            end
            tick();
        end
        ctrl_done = 1'b0;
        tests_run++;
        if (nstart !== 4) begin tests_failed++; $display("FAIL ovf_starts: got %0d want 4", nstart); end
        tests_run++;
        if (overflow !== 1'b1 || cfg_count !== 3'd0) begin
            tests_failed++; $display("FAIL ovf_sticky: ovf=%0b count=%0d want 1,0", overflow, cfg_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
        $display("[TB] overflow scenario ran %0d layers", nstart);
    endtask

    task automatic test_abort();
        int nstart, dly, bad;
        logic aborted;
        for (int k = 1; k <= 3; k++) begin
            push_desc(mk_mp(1, 1, 1, 1, 1), mk_sp1(1, 1, 1), mk_sp2(2), 32'(k + 16), 1'b0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        nstart = 0; dly = 0; aborted = 1'b0;
        for (int i = 0; i < 100 && !aborted; i++) begin
            ctrl_done = 1'b0;
            if (ctrl_start) begin
                nstart++;
                if (nstart == 1) begin
                    dly = 10;
                    tick();
                end else begin
                    tick();
                    tests_run++;
                    if (busy !== 1'b1 || layer_idx !== 8'd1) begin
                        tests_failed++; $display("FAIL abort_pre: busy=%0b idx=%0d want 1,1", busy, layer_idx);
                    end
                    abort = 1'b1; start = 1'b1; cfg_push = 1'b1;
                    tick();
                    abort = 1'b0; start = 1'b0; cfg_push = 1'b0;
                    aborted = 1'b1;
                    $display("[TB] abort issued in WAIT of layer 2");
                    tests_run++;
                    if (busy !== 1'b0 || cfg_count !== 3'd0 || done !== 1'b0 || layer_idx !== 8'd0 || ctrl_start !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL abort_post: busy=%0b count=%0d done=%0b idx=%0d cs=%0b want 0,0,0,0,0",
                                 busy, cfg_count, done, layer_idx, ctrl_start);
                    end
                end
            end else begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) ctrl_done = 1'b1;
                end
                tick();
            end
        end
        ctrl_done = 1'b0;
        tests_run++;
        if (aborted !== 1'b1) begin tests_failed++; $display("FAIL abort_reached: got %0b want 1", aborted); end
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy || done || ctrl_start) bad++;
            tick();
        end
        tests_run++;
        if (bad !== 0 || layer_idx !== 8'd0) begin
            tests_failed++; $display("FAIL abort_stray_done: activity=%0d idx=%0d want 0,0", bad, layer_idx);
        end
    endtask

    task automatic test_empty_start_and_e0();
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL empty_start: busy=%0b want 0", busy); end
        tick();
        tests_run++;
        if (busy !== 1'b0 || ctrl_start !== 1'b0) begin
            tests_failed++; $display("FAIL empty_start_hold: busy=%0b cs=%0b want 0,0", busy, ctrl_start);
        end
        push_desc(mk_mp(1, 1, 2, 1, 0), mk_sp1(2, 1, 3), mk_sp2(5), 32'h0000_00E0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!ctrl_start && lat < 20) begin tick(); lat++; end
        tests_run++;
        if (filter_baseaddr !== 32'd20 || bias_baseaddr !== 32'd24 || opsum_baseaddr !== 32'd28) begin
            tests_failed++;
            $display("FAIL e0_addrs: got filter=%0d bias=%0d opsum=%0d want 20,24,28", filter_baseaddr, bias_baseaddr, opsum_baseaddr);
        end
        $display("[TB] e=0 layer filter=%0d bias=%0d opsum=%0d", filter_baseaddr, bias_baseaddr, opsum_baseaddr);
        tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        push_desc(mk_mp(1, 1, 1, 1, 1), mk_sp1(1, 1, 1), mk_sp2(1), 32'd1, 1'b0);
        push_desc(mk_mp(1, 1, 1, 1, 1), mk_sp1(1, 1, 1), mk_sp2(1), 32'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_push = 1'b1;
        tick();
        cfg_push = 1'b0;
        $display("[TB] push+pop same cycle count=%0d", cfg_count);
        tests_run++;
        if (cfg_count !== 3'd2 || busy !== 1'b1 || op_config !== 32'd1) begin
            tests_failed++; $display("FAIL b2b_count: count=%0d busy=%0b op=%0d want 2,1,1", cfg_count, busy, op_config);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat, bad;
        push_desc(mk_mp(2, 1, 1, 2, 4), mk_sp1(3, 3, 1), mk_sp2(8), 32'hBEEF_0002, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!ctrl_start && lat < 20) begin tick(); lat++; end
        rst_n = 1'b0;
        #1;
        $display("[TB] reset asserted mid-RUN");
        tests_run++;
        if (ctrl_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_ctrl: cs=%0b busy=%0b done=%0b want 0,0,0", ctrl_start, busy, done);
        end
        tests_run++;
        if (filter_baseaddr !== 32'd0 || op_config !== 32'd0 || cfg_count !== 3'd0 || layer_idx !== 8'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_regs: filter=%0d op=%h count=%0d idx=%0d want 0", filter_baseaddr, op_config, cfg_count, layer_idx);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ctrl_start || done || busy) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL rst_mid_release: activity=%0d want 0", bad); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        cfg_wen   = 1'b0;
        cfg_wsel  = 3'd0;
        cfg_wdata = 32'd0;
        cfg_push  = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ctrl_done = 1'b0;
        test_reset();
        test_single_layer();
        test_multi_layer();
        test_overflow();
        test_abort();
        test_empty_start_and_e0();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
